// File: rtl/wb_arbiter_pkg.sv
// Shared writeback constants and the result record passed between arbiter sources.
package wb_arbiter_pkg;
  localparam int XLEN           = 32;
  localparam int NREG           = 32;
  localparam int REG_AW         = $clog2(NREG);
  localparam int STARVE_MAX_DEF = 4;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_res_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination tracker for in-flight M-unit ops; x0 is never marked busy.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] q_a,
  input  logic [REG_AW-1:0] q_b,
  input  logic [REG_AW-1:0] q_c,
  output logic              hit_a,
  output logic              hit_b,
  output logic              hit_c,
  output logic [NREG-1:0]   busy
);
  // Set is written after clear so a same-cycle reissue keeps the register owned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (clr_en)                 busy[clr_rd] <= 1'b0;
      if (set_en && set_rd != '0) busy[set_rd] <= 1'b1;
    end
  end

  assign hit_a = busy[q_a];
  assign hit_b = busy[q_b];
  assign hit_c = busy[q_c];
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipe vs M-unit with starvation guard, registered RF write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_wd,
  output logic              pipe_ready,
  input  logic              lu_valid,
  input  logic [REG_AW-1:0] lu_rd,
  input  logic [XLEN-1:0]   lu_wd,
  output logic              lu_ready,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  input  logic [REG_AW-1:0] q_rd,
  output logic              hz_stall,
  output logic              we,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   wd
);
  localparam int WAIT_W = $clog2(STARVE_MAX + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              starve, grant_lu, grant_pipe, grant;
  logic              hit1, hit2, hit3;
  logic [NREG-1:0]   busy;
  wb_res_t           pipe_res, lu_res, win;

  assign pipe_res   = '{rd: pipe_rd, wd: pipe_wd};
  assign lu_res     = '{rd: lu_rd, wd: lu_wd};

  // Pipe normally wins; the M-unit takes over once it has been refused STARVE_MAX times.
  assign starve     = (wait_cnt == WAIT_W'(STARVE_MAX));
  assign grant_lu   = lu_valid & (~pipe_valid | starve);
  assign grant_pipe = pipe_valid & ~grant_lu;
  assign grant      = grant_lu | grant_pipe;
  assign lu_ready   = grant_lu;
  assign pipe_ready = ~grant_lu;
  assign win        = grant_lu ? lu_res : pipe_res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    wait_cnt <= '0;
    else if (!lu_valid || grant_lu) wait_cnt <= '0;
    else if (!starve)            wait_cnt <= wait_cnt + 1'b1;
  end

  // x0 results complete the handshake but never raise the write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we <= 1'b0;
      rd <= '0;
      wd <= '0;
    end else begin
      we <= grant & (win.rd != '0);
      if (grant) begin
        rd <= win.rd;
        wd <= win.wd;
      end
    end
  end

  wb_scoreboard u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (iss_valid),
    .set_rd (iss_rd),
    .clr_en (grant_lu),
    .clr_rd (lu_rd),
    .q_a    (q_rs1),
    .q_b    (q_rs2),
    .q_c    (q_rd),
    .hit_a  (hit1),
    .hit_b  (hit2),
    .hit_c  (hit3),
    .busy   (busy)
  );

  assign hz_stall = hit1 | hit2 | hit3;

  a_iss_free: assert property (@(posedge clk) disable iff (!rst)
    (iss_valid && iss_rd != '0) |-> (!busy[iss_rd] || (grant_lu && lu_rd == iss_rd)));
  a_pipe_free: assert property (@(posedge clk) disable iff (!rst)
    grant_pipe |-> !busy[pipe_rd]);
  a_lu_owned: assert property (@(posedge clk) disable iff (!rst)
    (grant_lu && lu_rd != '0) |-> busy[lu_rd]);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reference model checked every cycle plus literal spot checks.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_valid, lu_valid, iss_valid;
  logic [REG_AW-1:0] pipe_rd, lu_rd, iss_rd, q_rs1, q_rs2, q_rd;
  logic [XLEN-1:0]   pipe_wd, lu_wd;
  logic              pipe_ready, lu_ready, hz_stall, we;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   wd;

  int total = 0;
  int bad   = 0;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd), .pipe_ready(pipe_ready),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wd(lu_wd), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .hz_stall(hz_stall),
    .we(we), .rd(rd), .wd(wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the RF port and scoreboard must hold after each edge.
  bit             m_we = 1'b0;
  bit [4:0]       m_rd = '0;
  bit [31:0]      m_wd = '0;
  bit [NREG-1:0]  m_busy = '0;
  int             m_refused = 0;

  function automatic bit lu_wins();
    return lu_valid && (!pipe_valid || m_refused >= STARVE_MAX_DEF);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_we = 1'b0; m_rd = '0; m_wd = '0; m_busy = '0; m_refused = 0;
    end else begin
      bit glu;
      glu = lu_wins();
      if (glu) begin
        m_we = (lu_rd != 0); m_rd = lu_rd; m_wd = lu_wd;
        m_busy[lu_rd] = 1'b0;
      end else if (pipe_valid) begin
        m_we = (pipe_rd != 0); m_rd = pipe_rd; m_wd = pipe_wd;
      end else begin
        m_we = 1'b0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      m_refused = (lu_valid && !glu) ? ((m_refused < STARVE_MAX_DEF) ? m_refused + 1 : m_refused) : 0;
    end
  end

  always @(negedge clk) begin
    bit glu;
    glu = lu_wins();
    chk("m_lu_ready", 32'(lu_ready), 32'(glu));
    chk("m_pipe_ready", 32'(pipe_ready), 32'(!glu));
    chk("m_hz_stall", 32'(hz_stall), 32'(m_busy[q_rs1] | m_busy[q_rs2] | m_busy[q_rd]));
    chk("m_we", 32'(we), 32'(m_we));
    chk("m_rd", 32'(rd), 32'(m_rd));
    chk("m_wd", wd, m_wd);
  end

  task automatic idle();
    pipe_valid = 0; pipe_rd = '0; pipe_wd = '0;
    lu_valid = 0; lu_rd = '0; lu_wd = '0;
    iss_valid = 0; iss_rd = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [4:0] r);
    iss_valid = 1; iss_rd = r;
    step(); idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_pipe_ready", 32'(pipe_ready), 32'd1);
    chk("rst_lu_ready", 32'(lu_ready), 32'd0);
    chk("rst_hz", 32'(hz_stall), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // pipe only
    step();
    pipe_valid = 1; pipe_rd = 5'd5; pipe_wd = 32'hDEADBEEF;
    #1 chk("pipe_ready", 32'(pipe_ready), 32'd1);
    step(); idle();
    chk("pipe_we", 32'(we), 32'd1);
    chk("pipe_rd", 32'(rd), 32'd5);
    chk("pipe_wd", wd, 32'hDEADBEEF);

    // conflict: pipe wins, M-unit waits one cycle
    issue(5'd7);
    pipe_valid = 1; pipe_rd = 5'd3; pipe_wd = 32'h33;
    lu_valid = 1; lu_rd = 5'd7; lu_wd = 32'h77;
    #1 chk("cf_lu_ready", 32'(lu_ready), 32'd0);
    chk("cf_pipe_ready", 32'(pipe_ready), 32'd1);
    step();
    chk("cf_we", 32'(we), 32'd1);
    chk("cf_rd", 32'(rd), 32'd3);
    chk("cf_wait_cnt", 32'(dut.wait_cnt), 32'd1);
    pipe_valid = 0;
    #1 chk("cf_lu_ready2", 32'(lu_ready), 32'd1);
    step(); idle();
    chk("cf_lu_rd", 32'(rd), 32'd7);
    chk("cf_lu_wd", wd, 32'h77);

    // starvation: M-unit granted in cycle 4
    issue(5'd10);
    pipe_valid = 1; pipe_rd = 5'd4; pipe_wd = 32'h44;
    lu_valid = 1; lu_rd = 5'd10; lu_wd = 32'hA0;
    for (int i = 0; i <= 4; i++) begin
      #1;
      chk($sformatf("sv_lu_ready_c%0d", i), 32'(lu_ready), 32'(i == 4));
      chk($sformatf("sv_pipe_ready_c%0d", i), 32'(pipe_ready), 32'(i != 4));
      if (i < 4) step();
    end
    step(); idle();
    chk("sv_we", 32'(we), 32'd1);
    chk("sv_rd", 32'(rd), 32'd10);
    chk("sv_wd", wd, 32'hA0);

    // scoreboard hazard on rd 9
    issue(5'd9);
    q_rs1 = 5'd9;
    #1 chk("sb_hz_rs1", 32'(hz_stall), 32'd1);
    step();
    q_rs1 = 5'd9;
    #1 chk("sb_hz_hold", 32'(hz_stall), 32'd1);
    q_rs1 = '0; q_rd = 5'd9;
    #1 chk("sb_hz_rd", 32'(hz_stall), 32'd1);
    q_rd = '0; q_rs2 = 5'd9;
    #1 chk("sb_hz_rs2", 32'(hz_stall), 32'd1);
    lu_valid = 1; lu_rd = 5'd9; lu_wd = 32'h99;
    #1 chk("sb_lu_ready", 32'(lu_ready), 32'd1);
    chk("sb_hz_commit", 32'(hz_stall), 32'd1);
    step();
    lu_valid = 0;
    #1 chk("sb_hz_clear", 32'(hz_stall), 32'd0);
    chk("sb_we", 32'(we), 32'd1);
    chk("sb_rd", 32'(rd), 32'd9);
    idle();

    // same-cycle set and clear of rd 12: set wins
    issue(5'd12);
    lu_valid = 1; lu_rd = 5'd12; lu_wd = 32'hC1;
    iss_valid = 1; iss_rd = 5'd12;
    #1 chk("sw_lu_ready", 32'(lu_ready), 32'd1);
    step(); idle();
    q_rs1 = 5'd12;
    #1 chk("sw_hz", 32'(hz_stall), 32'd1);
    chk("sw_rd", 32'(rd), 32'd12);
    lu_valid = 1; lu_rd = 5'd12; lu_wd = 32'hC2;
    step(); idle();
    q_rs1 = 5'd12;
    #1 chk("sw_hz_clear", 32'(hz_stall), 32'd0);
    idle();

    // x0 result: accepted, no write enable
    lu_valid = 1; lu_rd = 5'd0; lu_wd = 32'h1234;
    #1 chk("x0_lu_ready", 32'(lu_ready), 32'd1);
    step(); idle();
    chk("x0_we", 32'(we), 32'd0);
    chk("x0_rd", 32'(rd), 32'd0);
    chk("x0_wd", wd, 32'h1234);
    chk("x0_busy", dut.busy, 32'd0);

    // reset mid-traffic
    issue(5'd20);
    pipe_valid = 1; pipe_rd = 5'd6; pipe_wd = 32'h66; q_rs1 = 5'd20;
    #1 chk("mr_hz_pre", 32'(hz_stall), 32'd1);
    step();
    chk("mr_we_pre", 32'(we), 32'd1);
    chk("mr_rd_pre", 32'(rd), 32'd6);
    #1 rst = 1'b0;
    #1;
    chk("mr_we", 32'(we), 32'd0);
    chk("mr_rd", 32'(rd), 32'd0);
    chk("mr_wd", wd, 32'd0);
    chk("mr_hz", 32'(hz_stall), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
